// File: rtl/ball_motion_if.sv
// Ball-stage bus: frame strobe, serve request and paddle positions in;
// ball position, direction, state and point pulses out.
interface ball_motion_if;
    logic       tick;
    logic       start;
    logic [9:0] player_paddle_y;
    logic [9:0] ai_paddle_y;
    logic [9:0] ball_pos_x;
    logic [9:0] ball_pos_y;
    logic       ball_dir_x;
    logic       ball_dir_y;
    logic [1:0] ball_state;
    logic       point_player;
    logic       point_ai;

    modport master (
        output tick, start, player_paddle_y, ai_paddle_y,
        input  ball_pos_x, ball_pos_y, ball_dir_x, ball_dir_y,
               ball_state, point_player, point_ai
    );

    modport slave (
        input  tick, start, player_paddle_y, ai_paddle_y,
        output ball_pos_x, ball_pos_y, ball_dir_x, ball_dir_y,
               ball_state, point_player, point_ai
    );
endinterface

// File: rtl/ball_motion.sv
// Pong ball: serve sequencing, per-tick motion, wall and paddle bounces,
// and one-cycle point pulses when a paddle misses.
module ball_motion #(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int BALL_SIZE      = 8,
    parameter int PADDLE_W       = 8,
    parameter int PADDLE_H       = 64,
    parameter int LEFT_PADDLE_X  = 16,
    parameter int RIGHT_PADDLE_X = 616,
    parameter int STEP           = 2,
    parameter int SERVE_DELAY    = 60
) (
    input  logic          clk,
    input  logic          reset,
    ball_motion_if.slave  bus
);
    localparam int CNT_W = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);

    localparam logic [10:0] C_STEP   = 11'(STEP);
    localparam logic [10:0] C_BALL   = 11'(BALL_SIZE);
    localparam logic [10:0] C_PH     = 11'(PADDLE_H);
    localparam logic [10:0] C_XMAX   = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] C_YMAX   = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] C_RHIT   = 11'(RIGHT_PADDLE_X);
    localparam logic [10:0] C_RSTOP  = 11'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic [10:0] C_LFACE  = 11'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [9:0]  C_XMID   = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]  C_YMID   = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [CNT_W-1:0] C_DELAY = CNT_W'(SERVE_DELAY);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_PLAY   = 2'd2,
        ST_SCORED = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [9:0]       x_reg, x_next, y_reg, y_next;
    logic             dir_x_reg, dir_x_next, dir_y_reg, dir_y_next;
    logic             point_player_reg, point_player_next;
    logic             point_ai_reg, point_ai_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Candidate next positions for a PLAY tick, computed in 11 bits
    logic [10:0] xw, yw, ai_w, pl_w, x_upd, y_upd;
    logic        dy_upd, dx_upd, ov_ai, ov_pl, miss_right, miss_left;

    always_comb begin
        xw     = {1'b0, x_reg};
        yw     = {1'b0, y_reg};
        ai_w   = {1'b0, bus.ai_paddle_y};
        pl_w   = {1'b0, bus.player_paddle_y};
        ov_ai  = (yw + C_BALL > ai_w) && (yw < ai_w + C_PH);
        ov_pl  = (yw + C_BALL > pl_w) && (yw < pl_w + C_PH);

        y_upd  = yw;
        dy_upd = dir_y_reg;
        if (dir_y_reg && (yw + C_STEP >= C_YMAX)) begin
            y_upd  = C_YMAX;
            dy_upd = 1'b0;
        end else if (!dir_y_reg && (yw < C_STEP)) begin
            y_upd  = 11'd0;
            dy_upd = 1'b1;
        end else if (dir_y_reg) begin
            y_upd = yw + C_STEP;
        end else begin
            y_upd = yw - C_STEP;
        end

        x_upd      = xw;
        dx_upd     = dir_x_reg;
        miss_right = 1'b0;
        miss_left  = 1'b0;
        if (dir_x_reg) begin
            if ((xw + C_BALL <= C_RHIT) && (xw + C_BALL + C_STEP >= C_RHIT) && ov_ai) begin
                x_upd  = C_RSTOP;
                dx_upd = 1'b0;
            end else if (xw + C_STEP >= C_XMAX) begin
                x_upd      = C_XMAX;
                miss_right = 1'b1;
            end else begin
                x_upd = xw + C_STEP;
            end
        end else begin
            // x - STEP <= face is rewritten as x <= face + STEP to stay unsigned
            if ((xw >= C_LFACE) && (xw <= C_LFACE + C_STEP) && ov_pl) begin
                x_upd  = C_LFACE;
                dx_upd = 1'b1;
            end else if (xw < C_STEP) begin
                x_upd     = 11'd0;
                miss_left = 1'b1;
            end else begin
                x_upd = xw - C_STEP;
            end
        end
    end

    always_comb begin
        state_next        = state_reg;
        x_next            = x_reg;
        y_next            = y_reg;
        dir_x_next        = dir_x_reg;
        dir_y_next        = dir_y_reg;
        cnt_next          = cnt_reg;
        point_player_next = 1'b0;
        point_ai_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_SERVE;
                    cnt_next   = C_DELAY;
                end
            end
            ST_SERVE: begin
                if (bus.tick) begin
                    if (cnt_reg == C_ONE) begin
                        state_next = ST_PLAY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - C_ONE;
                    end
                end
            end
            ST_PLAY: begin
                if (bus.tick) begin
                    x_next            = x_upd[9:0];
                    y_next            = y_upd[9:0];
                    dir_x_next        = dx_upd;
                    dir_y_next        = dy_upd;
                    point_player_next = miss_right;
                    point_ai_next     = miss_left;
                    if (miss_right || miss_left) begin
                        state_next = ST_SCORED;
                    end
                end
            end
            default: begin
                // dir_x already points at the side that conceded
                state_next = ST_SERVE;
                x_next     = C_XMID;
                y_next     = C_YMID;
                cnt_next   = C_DELAY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            x_reg            <= C_XMID;
            y_reg            <= C_YMID;
            dir_x_reg        <= 1'b1;
            dir_y_reg        <= 1'b1;
            cnt_reg          <= '0;
            point_player_reg <= 1'b0;
            point_ai_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            x_reg            <= x_next;
            y_reg            <= y_next;
            dir_x_reg        <= dir_x_next;
            dir_y_reg        <= dir_y_next;
            cnt_reg          <= cnt_next;
            point_player_reg <= point_player_next;
            point_ai_reg     <= point_ai_next;
        end
    end

    assign bus.ball_pos_x   = x_reg;
    assign bus.ball_pos_y   = y_reg;
    assign bus.ball_dir_x   = dir_x_reg;
    assign bus.ball_dir_y   = dir_y_reg;
    assign bus.ball_state   = state_reg;
    assign bus.point_player = point_player_reg;
    assign bus.point_ai     = point_ai_reg;
endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Owns the Pong ball: position, direction, wall/paddle bounces, scoring, serve sequencing.
- Sits upstream of the paddle stage. It feeds ball_pos_y to the AI paddle.
- It consumes both paddle top-edge y positions for collision checks.
- Its outputs also drive the renderer and the score counter.

Parameters:
SCREEN_W, 640, playfield width in pixels
SCREEN_H, 480, playfield height in pixels
BALL_SIZE, 8, ball square edge in pixels
PADDLE_W, 8, paddle width
PADDLE_H, 64, paddle height
LEFT_PADDLE_X, 16, player paddle left edge x
RIGHT_PADDLE_X, 616, AI paddle left edge x
STEP, 2, pixels moved per axis per tick
SERVE_DELAY, 60, ticks spent in SERVE before play starts

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
tick  in  1  one-cycle frame-rate update strobe
start  in  1  begin game from IDLE
player_paddle_y  in  10  player paddle top edge
ai_paddle_y  in  10  AI paddle top edge
ball_pos_x  out  10  ball left edge
ball_pos_y  out  10  ball top edge
ball_dir_x  out  1  1 = +x (toward AI), 0 = −x
ball_dir_y  out  1  1 = +y (down), 0 = up
ball_state  out  2  0 IDLE, 1 SERVE, 2 PLAY, 3 SCORED
point_player  out  1  one-cycle pulse: AI missed
point_ai  out  1  one-cycle pulse: player missed

Behaviour:
- Reset (reset==0 at posedge clk):
  - ball_pos_x=(SCREEN_W−BALL_SIZE)/2=316, ball_pos_y=(SCREEN_H−BALL_SIZE)/2=236.
  - dir_x=1, dir_y=1, state IDLE, both point outputs 0, serve counter 0.
  - Reset overrides everything, including mid-PLAY.
- All outputs are registered.
- Internal arithmetic uses 11-bit signed or unsigned values. Candidate positions never wrap.
- IDLE:
  - Ball is held at centre. tick is ignored.
  - start==1 → SERVE, with counter loaded to SERVE_DELAY.
  - start is ignored in every other state.
- SERVE:
  - Ball is held at centre.
  - Each tick decrements the counter.
  - A tick that arrives while counter==1 → PLAY. SERVE therefore lasts exactly SERVE_DELAY ticks.
- PLAY: one update per tick. Positions are unchanged between ticks. Paddle inputs are sampled on the tick cycle only.
- Vertical axis:
  - dir_y=1 and y+STEP ≥ SCREEN_H−BALL_SIZE → y=SCREEN_H−BALL_SIZE, dir_y←0.
  - dir_y=0 and y < STEP → y=0, dir_y←1.
  - Otherwise y ± STEP.
- Vertical overlap with a paddle: (y+BALL_SIZE > paddle_y) and (y < paddle_y+PADDLE_H), evaluated on the pre-update y.
- Moving right (dir_x=1):
  - Hit: x+BALL_SIZE ≤ RIGHT_PADDLE_X, x+BALL_SIZE+STEP ≥ RIGHT_PADDLE_X, and overlap with ai_paddle_y → x=RIGHT_PADDLE_X−BALL_SIZE, dir_x←0.
  - Miss: else if x+STEP ≥ SCREEN_W−BALL_SIZE → x=SCREEN_W−BALL_SIZE, state→SCORED, point_player=1.
  - Otherwise x+STEP.
- Moving left (dir_x=0):
  - Hit: x ≥ LEFT_PADDLE_X+PADDLE_W, x−STEP ≤ LEFT_PADDLE_X+PADDLE_W, and overlap with player_paddle_y → x=LEFT_PADDLE_X+PADDLE_W, dir_x←1.
  - Miss: else if x < STEP → x=0, state→SCORED, point_ai=1.
  - Otherwise x−STEP.
- Simultaneous wall and paddle events in one tick: both axes update independently in the same cycle.
- SCORED:
  - Lasts exactly one clk cycle; the point pulse is high only in this cycle.
  - Next cycle → SERVE: ball recentred, counter=SERVE_DELAY.
  - dir_x points toward the side that conceded (point_player → dir_x=1; point_ai → dir_x=0). dir_y is preserved.
- Paddle inputs are used as given, with no clamping.

Test Plan:
1. Reset and idle: hold reset=0 for 2 cycles, then pulse tick 5× with no start → x=316, y=236, state 0, point outputs stay 0.
2. Serve timing: SERVE_DELAY=4, pulse start, then 4 ticks → state 1 through the 3rd tick, state 2 after the 4th. The first PLAY tick gives x 318, y 238.
3. Bottom bounce then AI hit: SERVE_DELAY=4, ai_paddle_y=400.
   - PLAY tick 118 → y=472, dir_y=0, x=552.
   - Tick 146 → x=608, y=416, dir_x=0.
   - No point pulse occurs.
4. AI miss: as scenario 3 but ai_paddle_y=0.
   - Tick 146 passes through at x=608.
   - Tick 158 → x=632, state 3, point_player high for exactly 1 cycle.
   - Then state 1, ball at (316,236), dir_x=1.
5. Reset mid-play: drive reset=0 for 1 cycle during PLAY with tick=1 → next cycle shows IDLE reset values. Subsequent ticks cause no movement.
6. Continuous tick and stray start: hold tick=1 every cycle and pulse start during PLAY → ball moves STEP every cycle, state stays PLAY, start has no effect.
